// File: rtl/db_pkg.sv
// ============================================================================
// Module  : db_pkg
// Purpose : Shared types and constants for the debug-bridge slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package db_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT_WAIT = 3'd1,
        ST_MEM_REQ   = 3'd2,
        ST_RF_ACC    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CMD_PAUSE  = 3'd0,
        CMD_RESUME = 3'd1,
        CMD_MEM_RD = 3'd2,
        CMD_MEM_WR = 3'd3,
        CMD_REG_RD = 3'd4,
        CMD_REG_WR = 3'd5
    } cmd_t;

    // Bit positions of each select line inside the packed select vector.
    localparam int unsigned c_SEL_W      = 6;
    localparam int unsigned c_SEL_PAUSE  = 0;
    localparam int unsigned c_SEL_RESUME = 1;
    localparam int unsigned c_SEL_MEM_RD = 2;
    localparam int unsigned c_SEL_MEM_WR = 3;
    localparam int unsigned c_SEL_REG_RD = 4;
    localparam int unsigned c_SEL_REG_WR = 5;

    localparam int unsigned c_TIMEOUT_DEFAULT = 1024;

    // Only meaningful when exactly one select bit is set.
    function automatic cmd_t sel_to_cmd(input logic [c_SEL_W-1:0] sel);
        cmd_t w_cmd;
        case (sel)
            6'b000010: w_cmd = CMD_RESUME;
            6'b000100: w_cmd = CMD_MEM_RD;
            6'b001000: w_cmd = CMD_MEM_WR;
            6'b010000: w_cmd = CMD_REG_RD;
            6'b100000: w_cmd = CMD_REG_WR;
            default:   w_cmd = CMD_PAUSE;
        endcase
        return w_cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/db_mcu_bridge_if.sv
// ============================================================================
// Module  : db_mcu_bridge_if
// Purpose : Command channel between mcu_controller (master) and the bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface db_mcu_bridge_if;

    logic        valid;
    logic        pause;
    logic        resume;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        mcu_busy;
    logic [31:0] d_rd;
    logic        error;

    modport master (
        output valid, pause, resume, mem_rd, mem_wr, reg_rd, reg_wr, addr, d_in,
        input  mcu_busy, d_rd, error
    );

    modport slave (
        input  valid, pause, resume, mem_rd, mem_wr, reg_rd, reg_wr, addr, d_in,
        output mcu_busy, d_rd, error
    );

endinterface

`default_nettype wire

// File: rtl/db_timeout_ctr.sv
// ============================================================================
// Module  : db_timeout_ctr
// Purpose : Saturating wait counter; flags the TIMEOUT-th enabled cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module db_timeout_ctr
    import db_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned            c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]     c_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]     c_MAX   = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0]     c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // r_cnt holds the number of already-elapsed wait cycles.
    assign expired = enable && (r_cnt >= c_LAST);

endmodule

`default_nettype wire

// File: rtl/db_mcu_bridge.sv
// ============================================================================
// Module  : db_mcu_bridge
// Purpose : Debug bridge turning controller commands into CPU halt, memory
//           and register-file accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module db_mcu_bridge
    import db_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    db_mcu_bridge_if.slave        cmd,
    output logic                  mcu_pause,
    input  logic                  cpu_halted,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [4:0]            rf_addr,
    output logic [31:0]           rf_wdata,
    output logic                  rf_we,
    input  logic [31:0]           rf_rdata
);

    state_t             r_state,     w_state_nxt;
    cmd_t               r_cmd,       w_cmd_nxt;
    logic               r_mcu_pause, w_pause_nxt;
    logic               r_error,     w_error_nxt;
    logic [31:0]        r_d_rd,      w_d_rd_nxt;
    logic               r_mem_re,    w_mem_re_nxt;
    logic               r_mem_we,    w_mem_we_nxt;
    logic [31:0]        r_mem_addr,  w_mem_addr_nxt;
    logic [31:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic               r_rf_we,     w_rf_we_nxt;
    logic [4:0]         r_rf_addr,   w_rf_addr_nxt;
    logic [31:0]        r_rf_wdata,  w_rf_wdata_nxt;

    logic [c_SEL_W-1:0] w_sel;
    cmd_t               w_cmd;
    logic               w_sel_ok;
    logic               w_access_ok;
    logic               w_ctr_clear;
    logic               w_ctr_en;
    logic               w_expired;

    always_comb begin
        w_sel               = '0;
        w_sel[c_SEL_PAUSE]  = cmd.pause;
        w_sel[c_SEL_RESUME] = cmd.resume;
        w_sel[c_SEL_MEM_RD] = cmd.mem_rd;
        w_sel[c_SEL_MEM_WR] = cmd.mem_wr;
        w_sel[c_SEL_REG_RD] = cmd.reg_rd;
        w_sel[c_SEL_REG_WR] = cmd.reg_wr;
    end

    assign w_cmd       = sel_to_cmd(w_sel);
    assign w_sel_ok    = $onehot(w_sel);
    assign w_access_ok = r_mcu_pause && cpu_halted;

    // Counter is held clear while idle so every wait starts from zero.
    assign w_ctr_clear = (r_state == ST_IDLE);
    assign w_ctr_en    = (r_state == ST_HALT_WAIT) || (r_state == ST_MEM_REQ);

    db_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_ctr_clear),
        .enable  (w_ctr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_PAUSE;
            r_mcu_pause <= 1'b0;
            r_error     <= 1'b0;
            r_d_rd      <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rf_we     <= 1'b0;
            r_rf_addr   <= '0;
            r_rf_wdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_mcu_pause <= w_pause_nxt;
            r_error     <= w_error_nxt;
            r_d_rd      <= w_d_rd_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rf_we     <= w_rf_we_nxt;
            r_rf_addr   <= w_rf_addr_nxt;
            r_rf_wdata  <= w_rf_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_pause_nxt     = r_mcu_pause;
        w_error_nxt     = r_error;
        w_d_rd_nxt      = r_d_rd;
        w_mem_re_nxt    = r_mem_re;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rf_we_nxt     = 1'b0;
        w_rf_addr_nxt   = r_rf_addr;
        w_rf_wdata_nxt  = r_rf_wdata;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd.valid) begin
                    w_cmd_nxt   = w_cmd;
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_DONE;
                    if (!w_sel_ok) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        unique case (w_cmd)
                            CMD_PAUSE: begin
                                w_pause_nxt = 1'b1;
                                w_state_nxt = ST_HALT_WAIT;
                            end
                            CMD_RESUME: begin
                                w_pause_nxt = 1'b0;
                            end
                            CMD_MEM_RD, CMD_MEM_WR: begin
                                if (!w_access_ok || (cmd.addr[1:0] != 2'b00)) begin
                                    w_error_nxt = 1'b1;
                                end else begin
                                    w_mem_addr_nxt  = cmd.addr;
                                    w_mem_wdata_nxt = cmd.d_in;
                                    w_mem_re_nxt    = (w_cmd == CMD_MEM_RD);
                                    w_mem_we_nxt    = (w_cmd == CMD_MEM_WR);
                                    w_state_nxt     = ST_MEM_REQ;
                                end
                            end
                            CMD_REG_RD, CMD_REG_WR: begin
                                if (!w_access_ok || (cmd.addr[31:5] != '0)) begin
                                    w_error_nxt = 1'b1;
                                end else begin
                                    w_rf_addr_nxt  = cmd.addr[4:0];
                                    w_rf_wdata_nxt = cmd.d_in;
                                    w_rf_we_nxt    = (w_cmd == CMD_REG_WR);
                                    w_state_nxt    = ST_RF_ACC;
                                end
                            end
                            default: begin
                                w_error_nxt = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_HALT_WAIT: begin
                if (cpu_halted) begin
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_MEM_REQ: begin
                // An ack arriving on the final allowed cycle still wins.
                if (mem_ack) begin
                    w_mem_re_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_cmd == CMD_MEM_RD) begin
                        w_d_rd_nxt = mem_rdata;
                    end
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_mem_re_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_RF_ACC: begin
                if (r_cmd == CMD_REG_RD) begin
                    w_d_rd_nxt = rf_rdata;
                end
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd.mcu_busy = cmd.valid || (r_state != ST_IDLE);
    assign cmd.d_rd     = r_d_rd;
    assign cmd.error    = r_error;
    assign mcu_pause    = r_mcu_pause;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_re       = r_mem_re;
    assign mem_we       = r_mem_we;
    assign rf_addr      = r_rf_addr;
    assign rf_wdata     = r_rf_wdata;
    assign rf_we        = r_rf_we;

endmodule

`default_nettype wire

// File: tb/tb_db_mcu_bridge.sv
// ============================================================================
// Module  : tb_db_mcu_bridge
// Purpose : Directed plus randomized self-checking bench for db_mcu_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_db_mcu_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        mcu_pause;
    logic        cpu_halted;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [31:0] rf_rdata;

    int total;
    int bad;

    // Reference model state: halt request, last read result, register file.
    logic        m_paused;
    logic [31:0] m_d_rd;
    logic [31:0] m_rf [32];
    // Environment register file driven by the DUT's write port.
    logic [31:0] env_rf [32];

    db_mcu_bridge_if cmd_if ();

    db_mcu_bridge #(
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .mcu_pause  (mcu_pause),
        .cpu_halted (cpu_halted),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rf_we      (rf_we),
        .rf_rdata   (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_sel(input logic v, input logic [5:0] sel);
        cmd_if.valid  = v;
        cmd_if.pause  = sel[0];
        cmd_if.resume = sel[1];
        cmd_if.mem_rd = sel[2];
        cmd_if.mem_wr = sel[3];
        cmd_if.reg_rd = sel[4];
        cmd_if.reg_wr = sel[5];
    endtask

    // sel bits: 0 pause, 1 resume, 2 mem_rd, 3 mem_wr, 4 reg_rd, 5 reg_wr
    task automatic do_cmd(input string tag, input logic [5:0] sel, input logic [31:0] a,
                          input logic [31:0] din, input int hdly, input int adly,
                          input logic [31:0] rdata);
        int          exp_busy, exp_re, exp_we, exp_rfwe, n;
        int          cyc, busy_cnt, re_cnt, we_cnt, rfwe_cnt;
        logic        exp_err;
        logic [31:0] exp_drd, ack_addr, ack_wdata;
        bit          is_pause;

        is_pause = (sel == 6'b000001);
        exp_busy = 1; exp_re = 0; exp_we = 0; exp_rfwe = 0; n = 0;
        exp_err  = 1'b0;
        exp_drd  = m_d_rd;
        if ($countones(sel) != 1) begin
            exp_err = 1'b1;
        end else if (sel[0]) begin
            m_paused = 1'b1;
            if (cpu_halted)       exp_busy = 2;
            else if (hdly <= TMO) exp_busy = hdly + 1;
            else begin
                exp_busy = TMO + 1;
                exp_err  = 1'b1;
            end
        end else if (sel[1]) begin
            m_paused = 1'b0;
        end else if (!(m_paused && cpu_halted)) begin
            exp_err = 1'b1;
        end else if (sel[2] || sel[3]) begin
            if (a[1:0] != 2'b00) begin
                exp_err = 1'b1;
            end else begin
                n        = (adly < TMO) ? adly + 1 : TMO;
                exp_busy = n + 1;
                exp_err  = (adly >= TMO);
                if (sel[2]) begin
                    exp_re = n;
                    if (!exp_err) exp_drd = rdata;
                end else begin
                    exp_we = n;
                end
            end
        end else begin
            if (a[31:5] != '0) begin
                exp_err = 1'b1;
            end else begin
                exp_busy = 2;
                if (sel[5]) begin
                    exp_rfwe       = 1;
                    m_rf[a[4:0]]   = din;
                end else begin
                    exp_drd = m_rf[a[4:0]];
                end
            end
        end

        drive_sel(1'b1, sel);
        cmd_if.addr = a;
        cmd_if.d_in = din;
        #1;
        chk({tag, "/busy_at_valid"}, cmd_if.mcu_busy, 1);
        @(posedge clk); #1;
        drive_sel(1'b0, 6'b0);
        cmd_if.addr = $urandom;
        cmd_if.d_in = $urandom;
        #1;
        if (is_pause)          chk({tag, "/pause_n1"}, mcu_pause, 1);
        if (sel == 6'b000010)  chk({tag, "/resume_n1"}, mcu_pause, 0);

        cyc = 1; busy_cnt = 0; re_cnt = 0; we_cnt = 0; rfwe_cnt = 0;
        ack_addr = '0; ack_wdata = '0;
        while (cmd_if.mcu_busy && cyc <= 40) begin
            busy_cnt++;
            if (is_pause && cyc == hdly && mcu_pause) cpu_halted = 1'b1;
            re_cnt += int'(mem_re);
            we_cnt += int'(mem_we);
            if ((mem_re || mem_we) && cyc == adly + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                ack_addr  = mem_addr;
                ack_wdata = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (rf_we) begin
                rfwe_cnt++;
                env_rf[rf_addr] = rf_wdata;
            end
            rf_rdata = env_rf[rf_addr];
            @(posedge clk); #2;
            cyc++;
        end
        mem_ack = 1'b0;

        chk({tag, "/busy_end"},    cmd_if.mcu_busy, 0);
        chk({tag, "/busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "/error"},       cmd_if.error, exp_err);
        chk({tag, "/d_rd"},        cmd_if.d_rd, exp_drd);
        chk({tag, "/mcu_pause"},   mcu_pause, m_paused);
        chk({tag, "/mem_re_cyc"},  re_cnt, exp_re);
        chk({tag, "/mem_we_cyc"},  we_cnt, exp_we);
        chk({tag, "/rf_we_cyc"},   rfwe_cnt, exp_rfwe);
        if ((exp_re != 0 || exp_we != 0) && !exp_err)
            chk({tag, "/mem_addr"}, ack_addr, a);
        if (exp_we != 0 && !exp_err)
            chk({tag, "/mem_wdata"}, ack_wdata, din);
        if (exp_rfwe != 0)
            chk({tag, "/rf_write"}, env_rf[a[4:0]], din);

        if (sel == 6'b000010) cpu_halted = 1'b0;
        m_d_rd = exp_drd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_paused = 1'b0;
        m_d_rd   = '0;
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            env_rf[i] = '0;
        end
        rst = 1'b1;
        cpu_halted = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        rf_rdata = '0;
        drive_sel(1'b0, 6'b0);
        cmd_if.addr = '0;
        cmd_if.d_in = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst/busy",      cmd_if.mcu_busy, 0);
        chk("rst/error",     cmd_if.error, 0);
        chk("rst/d_rd",      cmd_if.d_rd, 0);
        chk("rst/mcu_pause", mcu_pause, 0);
        chk("rst/mem_re",    mem_re, 0);
        chk("rst/mem_we",    mem_we, 0);
        chk("rst/rf_we",     rf_we, 0);
        chk("rst/mem_addr",  mem_addr, 0);
        chk("rst/mem_wdata", mem_wdata, 0);
        chk("rst/rf_addr",   rf_addr, 0);
        chk("rst/rf_wdata",  rf_wdata, 0);

        do_cmd("multi_sel",    6'b000011, 32'h0,  32'h0,        0, 0,  32'h0);
        do_cmd("wr_unpaused",  6'b001000, 32'h4,  32'h0000A5A5, 0, 0,  32'h0);
        do_cmd("pause",        6'b000001, 32'h0,  32'h0,        5, 0,  32'h0);
        do_cmd("mem_rd",       6'b000100, 32'h10, 32'h0,        0, 3,  32'hDEADBEEF);
        do_cmd("reg_wr",       6'b100000, 32'h5,  32'h00001234, 0, 0,  32'h0);
        do_cmd("reg_rd",       6'b010000, 32'h5,  32'h0,        0, 0,  32'h0);
        do_cmd("rd_misalign",  6'b000100, 32'h2,  32'h0,        0, 0,  32'h55AA55AA);
        do_cmd("reg_range",    6'b010000, 32'h20, 32'h0,        0, 0,  32'h0);
        do_cmd("no_sel",       6'b000000, 32'h0,  32'h0,        0, 0,  32'h0);
        do_cmd("mem_tmo",      6'b000100, 32'h40, 32'h0,        0, 30, 32'h11111111);
        do_cmd("mem_wr",       6'b001000, 32'h80, 32'hCAFEF00D, 0, 0,  32'h0);
        do_cmd("mem_wr_last",  6'b001000, 32'h84, 32'h0BADF00D, 0, 7,  32'h0);
        do_cmd("repause",      6'b000001, 32'h0,  32'h0,        1, 0,  32'h0);
        do_cmd("resume",       6'b000010, 32'h0,  32'h0,        0, 0,  32'h0);
        do_cmd("reg_unpaused", 6'b010000, 32'h5,  32'h0,        0, 0,  32'h0);
        do_cmd("pause_tmo",    6'b000001, 32'h0,  32'h0,        9, 0,  32'h0);

        for (int i = 0; i < 200; i++) begin
            int          k;
            logic [5:0]  s;
            logic [31:0] a;
            k = $urandom_range(0, 11);
            a = $urandom;
            case (k)
                0, 1:    s = 6'b000001;
                2:       s = 6'b000010;
                3, 4:    s = 6'b000100;
                5, 6:    s = 6'b001000;
                7, 8:    s = 6'b010000;
                9:       s = 6'b100000;
                10:      s = 6'b000000;
                default: begin
                    s = 6'($urandom);
                    if ($countones(s) < 2) s = s | 6'b100001;
                end
            endcase
            if (k >= 3 && k <= 6 && $urandom_range(0, 5) != 0) a = {a[31:2], 2'b00};
            if (k >= 7 && k <= 9 && $urandom_range(0, 7) != 0) a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) cpu_halted = ~cpu_halted;
            do_cmd("rnd", s, a, $urandom, $urandom_range(1, 9), $urandom_range(0, 9), $urandom);
        end

        // Reset in the middle of a memory request.
        do_cmd("pre_rst_pause", 6'b000001, 32'h0, 32'h0, 1, 0, 32'h0);
        drive_sel(1'b1, 6'b000100);
        cmd_if.addr = 32'h100;
        @(posedge clk); #1;
        drive_sel(1'b0, 6'b0);
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst/mem_re_before", mem_re, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("midrst/mem_re",    mem_re, 0);
        chk("midrst/mcu_pause", mcu_pause, 0);
        chk("midrst/busy",      cmd_if.mcu_busy, 0);
        chk("midrst/error",     cmd_if.error, 0);
        chk("midrst/d_rd",      cmd_if.d_rd, 0);
        rst = 1'b0;
        m_paused   = 1'b0;
        m_d_rd     = '0;
        cpu_halted = 1'b0;
        do_cmd("post_rst_pause", 6'b000001, 32'h0, 32'h0, 3, 0, 32'h0);
        do_cmd("post_rst_reg",   6'b010000, 32'h5, 32'h0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
